// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: XLEN x NREG register file with NRP combinational read
// ports, one write-back port with same-cycle bypass, and a per-register
// in-flight write counter. The counter drives BUSY/STALL toward the decoder.
module reg_file_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NRP  = 2,
   parameter int CW   = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [NRP*AW-1:0]   RD_ADDR,
   input  logic [NRP-1:0]      RD_USE,
   output logic [NRP*XLEN-1:0] RD_DATA,
   output logic [NRP-1:0]      BUSY,
   output logic                STALL,
   input  logic                ISSUE_EN,
   input  logic [AW-1:0]       ISSUE_ADDR,
   output logic                ISSUE_READY,
   input  logic                WR_EN,
   input  logic [AW-1:0]       WR_ADDR,
   input  logic [XLEN-1:0]     WR_DATA,
   output logic                ERR
);

   localparam logic [AW:0]   NREG_W  = (AW+1)'(NREG);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Register 0 has no storage or counter; arrays start at index 1.
   logic [XLEN-1:0] regs [1:NREG-1];
   logic [CW-1:0]   cnt  [1:NREG-1];
   logic            err;

   logic            issue_hit;
   logic [AW-1:0]   issue_idx;
   logic            issue_ok;
   logic            wr_hit;
   logic [NREG-1:1] inc_vec;
   logic [NREG-1:1] dec_vec;
   logic            err_set;

   // Address refers to a real, non-zero register.
   function automatic logic in_range(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < NREG_W);
   endfunction

   assign issue_hit   = in_range(ISSUE_ADDR);
   assign issue_idx   = issue_hit ? ISSUE_ADDR : AW'(1);
   assign ISSUE_READY = !issue_hit || (cnt[issue_idx] != CNT_MAX);
   assign issue_ok    = ISSUE_EN && ISSUE_READY && issue_hit;
   assign wr_hit      = WR_EN && in_range(WR_ADDR);

   // Per-port read mux with write-back bypass; the last owed write being
   // bypassed this cycle clears BUSY early.
   for (genvar i = 0; i < NRP; i++) begin : g_rd
      logic [AW-1:0] a;
      logic [AW-1:0] idx;
      logic          hit;
      logic          byp;
      assign a   = RD_ADDR[i*AW +: AW];
      assign hit = in_range(a);
      assign idx = hit ? a : AW'(1);
      assign byp = wr_hit && (WR_ADDR == a);
      assign RD_DATA[i*XLEN +: XLEN] = !hit ? '0 : (byp ? WR_DATA : regs[idx]);
      assign BUSY[i] = hit && (cnt[idx] != '0) && !(byp && (cnt[idx] == CNT_ONE));
   end

   assign STALL = |(BUSY & RD_USE);
   assign ERR   = err;

   // Decode issue/write-back targets and detect write-backs nobody owed.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      err_set = 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
         inc_vec[r] = issue_ok && (ISSUE_ADDR == AW'(r));
         dec_vec[r] = wr_hit && (WR_ADDR == AW'(r));
         if (dec_vec[r] && (cnt[r] == '0))
            err_set = 1'b1;
      end
   end

   // Register writes, in-flight counter updates and sticky error flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int unsigned r = 1; r < NREG; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
         err <= 1'b0;
      end else begin
         for (int unsigned r = 1; r < NREG; r++) begin
            if (dec_vec[r])
               regs[r] <= WR_DATA;
            case ({inc_vec[r], dec_vec[r]})
               2'b10: cnt[r] <= cnt[r] + CNT_ONE;
               2'b01: if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_ONE;
               // Issue and write-back together: net zero unless nothing was
               // owed, in which case the new issue still needs its count.
               2'b11: if (cnt[r] == '0) cnt[r] <= CNT_ONE;
               default: ;
            endcase
         end
         if (err_set)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard with default parameters.
module tb_reg_file_scoreboard;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [9:0]  RD_ADDR;
   logic [1:0]  RD_USE;
   logic [63:0] RD_DATA;
   logic [1:0]  BUSY;
   logic        STALL;
   logic        ISSUE_EN;
   logic [4:0]  ISSUE_ADDR;
   logic        ISSUE_READY;
   logic        WR_EN;
   logic [4:0]  WR_ADDR;
   logic [31:0] WR_DATA;
   logic        ERR;

   int checks   = 0;
   int failures = 0;

   reg_file_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .NRP(2), .CW(2)) dut (
      .CLK(CLK), .RESET(RESET), .RD_ADDR(RD_ADDR), .RD_USE(RD_USE),
      .RD_DATA(RD_DATA), .BUSY(BUSY), .STALL(STALL), .ISSUE_EN(ISSUE_EN),
      .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_READY(ISSUE_READY), .WR_EN(WR_EN),
      .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd(input int p);
      return RD_DATA[p*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      RESET    = 1'b0;
      ISSUE_EN = 1'b0;
      WR_EN    = 1'b0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
   endtask

   task automatic issue(input logic [4:0] a);
      ISSUE_EN = 1'b1; ISSUE_ADDR = a;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] use_v);
      RD_ADDR = {a1, a0}; RD_USE = use_v;
   endtask

   initial begin
      idle();
      WR_ADDR = '0; WR_DATA = '0; ISSUE_ADDR = '0;
      set_rd(5'd0, 5'd0, 2'b00);
      RESET = 1'b1;
      tick();
      idle();

      // Preload x5/x31, then reset clears them
      wb(5'd5, 32'h0000AAAA); tick();
      wb(5'd31, 32'h0000BBBB); tick();
      idle();
      set_rd(5'd5, 5'd31, 2'b11);
      ISSUE_ADDR = 5'd5;
      #1;
      check_eq("preload_x5", rd(0), 32'h0000AAAA);
      check_eq("preload_x31", rd(1), 32'h0000BBBB);
      check_eq("preload_err", 32'(ERR), 32'd1);
      RESET = 1'b1; tick(); RESET = 1'b0;
      #1;
      check_eq("rst_x5", rd(0), 32'd0);
      check_eq("rst_x31", rd(1), 32'd0);
      check_eq("rst_busy", 32'(BUSY), 32'd0);
      check_eq("rst_stall", 32'(STALL), 32'd0);
      check_eq("rst_err", 32'(ERR), 32'd0);
      check_eq("rst_ready", 32'(ISSUE_READY), 32'd1);

      // Bypass on x3
      issue(5'd3); tick(); idle();
      set_rd(5'd3, 5'd0, 2'b01);
      #1;
      check_eq("x3_busy_pre", 32'(BUSY[0]), 32'd1);
      wb(5'd3, 32'hDEADBEEF);
      #1;
      check_eq("bypass_x3", rd(0), 32'hDEADBEEF);
      check_eq("bypass_busy", 32'(BUSY[0]), 32'd0);
      tick(); idle(); #1;
      check_eq("stored_x3", rd(0), 32'hDEADBEEF);
      tick(); #1;
      check_eq("stored_x3_b", rd(0), 32'hDEADBEEF);
      set_rd(5'd0, 5'd3, 2'b11);
      wb(5'd0, 32'h00001234);
      #1;
      check_eq("x0_bypass", rd(0), 32'd0);
      check_eq("x0_busy", 32'(BUSY), 32'd0);
      tick(); idle(); #1;
      check_eq("x0_after", rd(0), 32'd0);
      check_eq("x3_port1", rd(1), 32'hDEADBEEF);
      check_eq("err_after_x0", 32'(ERR), 32'd0);

      // Scoreboard stall on x7
      issue(5'd7); tick(); idle();
      set_rd(5'd1, 5'd7, 2'b10);
      #1;
      check_eq("x7_busy", 32'(BUSY[1]), 32'd1);
      check_eq("x7_stall", 32'(STALL), 32'd1);
      RD_USE = 2'b00; #1;
      check_eq("x7_nouse_stall", 32'(STALL), 32'd0);
      check_eq("x7_nouse_busy", 32'(BUSY[1]), 32'd1);
      RD_USE = 2'b10;
      wb(5'd7, 32'h00000055); #1;
      check_eq("x7_wb_busy", 32'(BUSY[1]), 32'd0);
      check_eq("x7_wb_stall", 32'(STALL), 32'd0);
      check_eq("x7_wb_data", rd(1), 32'h00000055);
      tick(); idle(); #1;
      check_eq("x7_after_busy", 32'(BUSY[1]), 32'd0);
      check_eq("x7_after_data", rd(1), 32'h00000055);
      check_eq("x7_after_err", 32'(ERR), 32'd0);

      // Three outstanding writes to x9 saturate the counter
      set_rd(5'd9, 5'd0, 2'b01);
      for (int k = 0; k < 3; k++) begin
         issue(5'd9); #1;
         check_eq($sformatf("x9_ready_%0d", k), 32'(ISSUE_READY), 32'd1);
         tick();
      end
      idle(); ISSUE_ADDR = 5'd9; #1;
      check_eq("x9_sat_ready", 32'(ISSUE_READY), 32'd0);
      check_eq("x9_sat_busy", 32'(BUSY[0]), 32'd1);
      ISSUE_ADDR = 5'd0; #1;
      check_eq("x0_ready_sat", 32'(ISSUE_READY), 32'd1);
      issue(5'd9); tick(); idle();
      wb(5'd9, 32'h00000091); #1;
      check_eq("x9_wb1_busy", 32'(BUSY[0]), 32'd1);
      tick(); idle(); #1;
      ISSUE_ADDR = 5'd9; #1;
      check_eq("x9_wb1_ready", 32'(ISSUE_READY), 32'd1);
      wb(5'd9, 32'h00000092); #1;
      check_eq("x9_wb2_busy", 32'(BUSY[0]), 32'd1);
      tick(); idle(); #1;
      check_eq("x9_after2_busy", 32'(BUSY[0]), 32'd1);
      wb(5'd9, 32'h00000093); #1;
      check_eq("x9_wb3_busy", 32'(BUSY[0]), 32'd0);
      tick(); idle(); #1;
      check_eq("x9_done_busy", 32'(BUSY[0]), 32'd0);
      check_eq("x9_done_data", rd(0), 32'h00000093);
      check_eq("x9_done_err", 32'(ERR), 32'd0);

      // Simultaneous issue and write-back on x4
      set_rd(5'd4, 5'd0, 2'b01);
      issue(5'd4); tick(); idle();
      issue(5'd4); wb(5'd4, 32'h00000044); tick(); idle(); #1;
      check_eq("x4_cnt1_busy", 32'(BUSY[0]), 32'd1);
      check_eq("x4_cnt1_err", 32'(ERR), 32'd0);
      check_eq("x4_cnt1_data", rd(0), 32'h00000044);
      wb(5'd4, 32'h00000045); tick(); idle(); #1;
      check_eq("x4_drained", 32'(BUSY[0]), 32'd0);
      check_eq("x4_drained_err", 32'(ERR), 32'd0);
      issue(5'd4); wb(5'd4, 32'h00000046); tick(); idle(); #1;
      check_eq("x4_cnt0_busy", 32'(BUSY[0]), 32'd1);
      check_eq("x4_cnt0_err", 32'(ERR), 32'd1);

      // Unowed write-back to x12 sets sticky ERR
      RESET = 1'b1; tick(); RESET = 1'b0; #1;
      check_eq("x4_rst_busy", 32'(BUSY[0]), 32'd0);
      check_eq("err_cleared", 32'(ERR), 32'd0);
      set_rd(5'd12, 5'd0, 2'b01);
      wb(5'd12, 32'h00000012); tick(); idle(); #1;
      check_eq("x12_err", 32'(ERR), 32'd1);
      check_eq("x12_data", rd(0), 32'h00000012);
      check_eq("x12_busy", 32'(BUSY[0]), 32'd0);
      tick(); tick(); #1;
      check_eq("x12_err_hold", 32'(ERR), 32'd1);
      RESET = 1'b1; tick(); RESET = 1'b0; #1;
      check_eq("x12_err_rst", 32'(ERR), 32'd0);

      // Reset discards the outstanding issue to x2
      set_rd(5'd2, 5'd0, 2'b01);
      issue(5'd2); tick(); idle(); #1;
      check_eq("x2_busy", 32'(BUSY[0]), 32'd1);
      RESET = 1'b1; tick(); RESET = 1'b0; #1;
      check_eq("x2_rst_busy", 32'(BUSY[0]), 32'd0);
      wb(5'd2, 32'h00000022); tick(); idle(); #1;
      check_eq("x2_stale_err", 32'(ERR), 32'd1);
      check_eq("x2_stale_data", rd(0), 32'h00000022);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised successor to the single-issue register file: an XLEN×NREG architectural register file with NRP combinational read ports, one write-back port, same-cycle write-to-read bypass and a per-register in-flight write counter (scoreboard). Sits in the ID stage. It tells the decoder whether each source operand is still owed by an older instruction (STALL), and it tracks multiple outstanding writes per destination so long-latency loads and back-to-back writers are handled without a separate hazard unit.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of registers; register 0 is hardwired zero
- AW, 5, address width, must be ≥ clog2(NREG)
- NRP, 2, number of read ports
- CW, 2, in-flight counter width; MAX = 2^CW − 1 outstanding writes per register

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high; one clock, one reset
- RD_ADDR  in  NRP*AW  read addresses; port i = bits [i*AW +: AW]
- RD_USE  in  NRP  port i operand actually needed by the current instruction
- RD_DATA  out  NRP*XLEN  read data, port i = bits [i*XLEN +: XLEN]
- BUSY  out  NRP  port i source still pending
- STALL  out  1  OR over i of (BUSY[i] & RD_USE[i])
- ISSUE_EN  in  1  instruction leaving ID that will write ISSUE_ADDR
- ISSUE_ADDR  in  AW  destination of issuing instruction
- ISSUE_READY  out  1  destination counter not saturated
- WR_EN  in  1  write-back valid
- WR_ADDR  in  AW  write-back destination
- WR_DATA  in  XLEN  write-back data
- ERR  out  1  sticky: write-back to a register with no outstanding write

## Operation
- Storage: NREG−1 XLEN registers plus a CW-bit counter cnt[r] per register. Register 0 has no storage or counter. It always reads 0, is never BUSY, and ignores writes and issues.
- Read port i, combinational:
  - RD_DATA = 0 if address 0.
  - Otherwise WR_DATA if WR_EN and WR_ADDR == RD_ADDR[i] (bypass).
  - Otherwise the stored value.
  - Addresses ≥ NREG read 0 and are never BUSY.
- BUSY[i] = cnt[a] != 0, except BUSY[i] = 0 when WR_EN, WR_ADDR == a and cnt[a] == 1, because the last owed value is being bypassed.
- ISSUE_READY = (ISSUE_ADDR == 0) or cnt[ISSUE_ADDR] != MAX. An issue is accepted only if ISSUE_EN & ISSUE_READY. A non-ready issue changes nothing, and the decoder must hold.
- Write: when WR_EN and WR_ADDR != 0, the register takes WR_DATA at the edge, regardless of its counter.
- Counter update per register r at the edge:
  - inc = issue accepted to r; dec = WR_EN to r.
  - inc & !dec: cnt + 1.
  - dec & !inc: cnt − 1 if cnt > 0. If cnt == 0, the counter stays 0 and ERR is set.
  - inc & dec: cnt unchanged if cnt > 0. If cnt == 0, cnt becomes 1 and ERR is set.
- ERR clears only on RESET.
- RESET: all registers = 0, all cnt = 0, ERR = 0. RESET overrides any same-cycle write or issue.

## Timing
- Reads, BUSY, STALL and ISSUE_READY: zero latency, combinational from inputs and current state.
- Write data is visible through the bypass in the same cycle. From storage it is visible from the cycle after the edge.
- Counter effects of an issue are visible on BUSY/ISSUE_READY the cycle after the accepting edge.
- Outputs during and after reset:
  - The cycle after RESET is sampled: RD_DATA = 0, BUSY = 0, STALL = 0, ISSUE_READY = 1, ERR = 0.
  - While RESET is high, combinational outputs still follow inputs and the current state.
- Reset mid-operation discards all outstanding counts. Write-backs arriving afterwards for pre-reset issues set ERR, and upstream must flush them.
- No multicycle paths. The read mux plus bypass compare must close in one cycle.

## Test plan
- Reset with registers preloaded: RESET for 1 cycle, then read x5/x31 → RD_DATA = 0, BUSY = 0, ERR = 0.
- Bypass: write x3 = 0xDEADBEEF with RD_ADDR[0] = 3 in the same cycle → RD_DATA[0] = 0xDEADBEEF that cycle and every following cycle. Then write x0 = 0x1234 → x0 still reads 0.
- Scoreboard stall: issue x7; next cycle RD_ADDR[1] = 7, RD_USE[1] = 1 → BUSY[1] = 1, STALL = 1. Write-back x7 = 0x55 → same cycle BUSY[1] = 0, STALL = 0, RD_DATA[1] = 0x55. With RD_USE[1] = 0 and x7 pending → STALL = 0.
- Multiple outstanding writes, CW = 2: three issues to x9 → ISSUE_READY = 0 for x9. A fourth issue is ignored. Three write-backs are needed before BUSY clears. The 2nd write-back does not clear BUSY.
- Simultaneous issue and write-back to x4 with cnt = 1 → cnt stays 1 and BUSY stays 1. With cnt = 0 → cnt = 1 and ERR = 1.
- Error/reset: write-back to x12 with nothing outstanding → ERR = 1, register updated, ERR holds until RESET. Issue x2, then RESET, then write-back x2 → ERR = 1.
